// File: rtl/sev_key_table_if.sv
// Request, programming and response bundle between the SEV key table and its neighbours.
// The master side issues requests and programs keys; the slave side is the key table.
interface sev_key_table_if #(
    parameter int ASID_W = 4,
    parameter int FCNT_W = 16,
    parameter int DATA_W = 64
);
    logic              prog_valid_i;
    logic              prog_clear_i;
    logic [ASID_W-1:0] prog_asid_i;
    logic [DATA_W-1:0] prog_key_i;

    logic              req_valid_i;
    logic              req_ready_o;
    logic [ASID_W-1:0] req_asid_i;
    logic              req_write_i;
    logic [DATA_W-1:0] req_data_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_key_o;
    logic [DATA_W-1:0] rsp_data_o;
    logic              rsp_write_o;
    logic              rsp_fault_o;
    logic [FCNT_W-1:0] fault_count_o;

    modport master (
        output prog_valid_i, prog_clear_i, prog_asid_i, prog_key_i,
        output req_valid_i, req_asid_i, req_write_i, req_data_i,
        output rsp_ready_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_key_o, rsp_data_o, rsp_write_o, rsp_fault_o,
        input  fault_count_o
    );

    modport slave (
        input  prog_valid_i, prog_clear_i, prog_asid_i, prog_key_i,
        input  req_valid_i, req_asid_i, req_write_i, req_data_i,
        input  rsp_ready_i,
        output req_ready_o,
        output rsp_valid_o, rsp_key_o, rsp_data_o, rsp_write_o, rsp_fault_o,
        output fault_count_o
    );
endinterface

// File: rtl/sev_key_table.sv
// Per-ASID key store feeding the SEV XOR stage through a single registered output slot.
// Requests from VMs without a programmed key are blanked, flagged and counted.
module sev_key_table #(
    parameter int ASID_W = 4,
    parameter int FCNT_W = 16,
    parameter int DATA_W = 64
) (
    input  logic           clk_i,
    input  logic           rst_i,
    sev_key_table_if.slave bus
);
    localparam int ENTRIES = 2**ASID_W;

    logic [DATA_W-1:0]  key_tab [ENTRIES];
    logic [ENTRIES-1:0] vld_tab;

    logic              accept;
    logic              is_hyp;
    logic              hit;
    logic [DATA_W-1:0] key_p0;
    logic [DATA_W-1:0] data_p0;
    logic              fault_p0;

    logic              vld_p1;
    logic [DATA_W-1:0] key_p1;
    logic [DATA_W-1:0] data_p1;
    logic              write_p1;
    logic              fault_p1;
    logic [FCNT_W-1:0] fcnt_p1;

    function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign bus.req_ready_o = !vld_p1 || bus.rsp_ready_i;
    assign accept          = bus.req_valid_i && bus.req_ready_o;
    assign is_hyp          = (bus.req_asid_i == '0);
    assign hit             = vld_tab[bus.req_asid_i];

    // Stage p0: table lookup; an unkeyed VM gets zero data so no plaintext leaks downstream
    always_comb begin
        key_p0   = '0;
        data_p0  = '0;
        fault_p0 = 1'b0;
        if (is_hyp) begin
            data_p0 = bus.req_data_i;
        end else if (hit) begin
            key_p0  = key_tab[bus.req_asid_i];
            data_p0 = bus.req_data_i;
        end else begin
            fault_p0 = 1'b1;
        end
    end

    // Entry 0 is the hypervisor and is never keyed, so writes to it are dropped
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_tab <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                key_tab[i] <= '0;
            end
        end else if (bus.prog_valid_i && (bus.prog_asid_i != '0)) begin
            if (bus.prog_clear_i) begin
                vld_tab[bus.prog_asid_i] <= 1'b0;
                key_tab[bus.prog_asid_i] <= '0;
            end else begin
                vld_tab[bus.prog_asid_i] <= 1'b1;
                key_tab[bus.prog_asid_i] <= bus.prog_key_i;
            end
        end
    end

    // Stage p1: output slot; payload only moves on accept so it holds while stalled or empty
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1   <= 1'b0;
            key_p1   <= '0;
            data_p1  <= '0;
            write_p1 <= 1'b0;
            fault_p1 <= 1'b0;
            fcnt_p1  <= '0;
        end else begin
            if (accept) begin
                vld_p1   <= 1'b1;
                key_p1   <= key_p0;
                data_p1  <= data_p0;
                write_p1 <= bus.req_write_i;
                fault_p1 <= fault_p0;
                if (fault_p0) begin
                    fcnt_p1 <= sat_inc(fcnt_p1);
                end
            end else if (bus.rsp_ready_i) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid_o   = vld_p1;
    assign bus.rsp_key_o     = key_p1;
    assign bus.rsp_data_o    = data_p1;
    assign bus.rsp_write_o   = write_p1;
    assign bus.rsp_fault_o   = fault_p1;
    assign bus.fault_count_o = fcnt_p1;
endmodule

// File: tb/tb_sev_key_table.sv
// Randomized and directed bench for sev_key_table against a behavioural key-table model.
// A narrow fault counter keeps the saturation scenario short.
module tb_sev_key_table;
    localparam int ASID_W   = 4;
    localparam int FCNT_W   = 8;
    localparam int DATA_W   = 64;
    localparam int NENT     = 2**ASID_W;
    localparam int CNT_MAX  = (1 << FCNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sev_key_table_if #(.ASID_W(ASID_W), .FCNT_W(FCNT_W), .DATA_W(DATA_W)) bus ();

    sev_key_table #(.ASID_W(ASID_W), .FCNT_W(FCNT_W), .DATA_W(DATA_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    // Reference model: key table plus the response the slot should be showing
    logic [63:0] m_key [NENT];
    bit          m_kv  [NENT];
    bit          m_vld;
    logic [63:0] m_rkey;
    logic [63:0] m_rdata;
    bit          m_rwr;
    bit          m_rfault;
    int          m_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) begin
            m_key[i] = '0;
            m_kv[i]  = 1'b0;
        end
        m_vld = 0; m_rkey = '0; m_rdata = '0; m_rwr = 0; m_rfault = 0; m_cnt = 0;
    endtask

    task automatic drive_idle();
        bus.prog_valid_i = 1'b0;
        bus.prog_clear_i = 1'b0;
        bus.prog_asid_i  = '0;
        bus.prog_key_i   = '0;
        bus.req_valid_i  = 1'b0;
        bus.req_asid_i   = '0;
        bus.req_write_i  = 1'b0;
        bus.req_data_i   = '0;
        bus.rsp_ready_i  = 1'b1;
    endtask

    task automatic check_outputs();
        chk("rsp_valid", bus.rsp_valid_o, m_vld);
        chk("rsp_key", bus.rsp_key_o, m_rkey);
        chk("rsp_data", bus.rsp_data_o, m_rdata);
        chk("rsp_write", bus.rsp_write_o, m_rwr);
        chk("rsp_fault", bus.rsp_fault_o, m_rfault);
        chk("fault_count", bus.fault_count_o, m_cnt);
    endtask

    // One clock: predict from the current inputs, take the edge, compare
    task automatic step();
        bit acc;
        int a;
        #1;
        chk("req_ready", bus.req_ready_o, (!m_vld || bus.rsp_ready_i));
        acc = bus.req_valid_i && (!m_vld || bus.rsp_ready_i);
        a   = int'(bus.req_asid_i);
        if (acc) begin
            m_vld = 1;
            m_rwr = bus.req_write_i;
            if (a == 0) begin
                m_rkey = '0; m_rdata = bus.req_data_i; m_rfault = 0;
            end else if (m_kv[a]) begin
                m_rkey = m_key[a]; m_rdata = bus.req_data_i; m_rfault = 0;
            end else begin
                m_rkey = '0; m_rdata = '0; m_rfault = 1;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end else if (bus.rsp_ready_i) begin
            m_vld = 0;
        end
        if (bus.prog_valid_i && bus.prog_asid_i != 0) begin
            m_kv[bus.prog_asid_i]  = !bus.prog_clear_i;
            m_key[bus.prog_asid_i] = bus.prog_clear_i ? 64'h0 : bus.prog_key_i;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic set_req(input int asid, input bit wr, input logic [63:0] data);
        bus.req_valid_i = 1'b1;
        bus.req_asid_i  = ASID_W'(asid);
        bus.req_write_i = wr;
        bus.req_data_i  = data;
    endtask

    task automatic set_prog(input int asid, input bit clr, input logic [63:0] key);
        bus.prog_valid_i = 1'b1;
        bus.prog_clear_i = clr;
        bus.prog_asid_i  = ASID_W'(asid);
        bus.prog_key_i   = key;
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        chk("rst_async_valid", bus.rsp_valid_o, 1'b0);
        chk("rst_async_ready", bus.req_ready_o, 1'b1);
        chk("rst_async_cnt", bus.fault_count_o, 0);
        model_reset();
        drive_idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs();
        chk("reset_ready", bus.req_ready_o, 1'b1);

        // T2: program then encrypt-path request
        set_prog(3, 0, 64'hA5A5_A5A5_0000_FFFF); step(); drive_idle();
        set_req(3, 1, 64'h1234); step(); drive_idle();
        chk("t2_key", bus.rsp_key_o, 64'hA5A5_A5A5_0000_FFFF);
        chk("t2_data", bus.rsp_data_o, 64'h1234);
        chk("t2_fault", bus.rsp_fault_o, 1'b0);

        // T3: unprogrammed VM
        set_req(5, 0, 64'hDEAD); step(); drive_idle();
        chk("t3_key", bus.rsp_key_o, 64'h0);
        chk("t3_data", bus.rsp_data_o, 64'h0);
        chk("t3_fault", bus.rsp_fault_o, 1'b1);
        chk("t3_cnt", bus.fault_count_o, 1);

        // T4: hypervisor passthrough, programming ASID 0 is ignored
        set_req(0, 0, 64'hBEEF); step(); drive_idle();
        chk("t4_data", bus.rsp_data_o, 64'hBEEF);
        chk("t4_fault", bus.rsp_fault_o, 1'b0);
        set_prog(0, 0, 64'h1); step(); drive_idle();
        set_req(0, 1, 64'hBEEF); step(); drive_idle();
        chk("t4_key0", bus.rsp_key_o, 64'h0);

        // T5: stall with a second request waiting
        set_req(3, 0, 64'h1); step();
        set_req(3, 0, 64'h2); bus.rsp_ready_i = 1'b0;
        step(); chk("t5_ready", bus.req_ready_o, 1'b0);
        step(); chk("t5_hold", bus.rsp_data_o, 64'h1);
        bus.rsp_ready_i = 1'b1; step(); drive_idle();
        chk("t5_second", bus.rsp_data_o, 64'h2);
        step();
        chk("t5_drain", bus.rsp_valid_o, 1'b0);

        // T6: same-cycle program and lookup, then clear
        set_prog(7, 0, 64'h77); set_req(7, 0, 64'h5); step(); drive_idle();
        chk("t6_prelookup", bus.rsp_fault_o, 1'b1);
        set_req(7, 0, 64'h6); step(); drive_idle();
        chk("t6_key", bus.rsp_key_o, 64'h77);
        set_prog(7, 1, 64'h0); step(); drive_idle();
        set_req(7, 1, 64'h7); step(); drive_idle();
        chk("t6_cleared", bus.rsp_fault_o, 1'b1);

        // T1: async reset with the slot full and stalled
        set_req(3, 1, 64'h99); step();
        bus.rsp_ready_i = 1'b0; bus.req_valid_i = 1'b0; step();
        chk("t1_full", bus.rsp_valid_o, 1'b1);
        async_reset();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            bus.prog_valid_i = ($urandom_range(3) == 0);
            bus.prog_clear_i = ($urandom_range(2) == 0);
            bus.prog_asid_i  = ASID_W'($urandom_range(NENT - 1));
            bus.prog_key_i   = {$urandom, $urandom};
            bus.req_valid_i  = $urandom_range(1);
            bus.req_asid_i   = ASID_W'($urandom_range(NENT - 1));
            bus.req_write_i  = $urandom_range(1);
            bus.req_data_i   = {$urandom, $urandom};
            bus.rsp_ready_i  = ($urandom_range(2) != 0);
            step();
        end
        drive_idle();
        step();

        // Saturation of the fault counter
        async_reset();
        set_req(9, 0, 64'h1);
        repeat (CNT_MAX + 2) step();
        drive_idle();
        step();
        chk("sat_cnt", bus.fault_count_o, CNT_MAX);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
